// File: rtl/line_writeback.sv
// Writes one 64-byte cache line to memory: arbitrate for the bus, send one
// address phase, stream eight data beats, then release the bus and report ready.
module line_writeback #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0] WRITE_TAG = 13'h1100
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [63:0]                 addr,
  input  logic [8*BUS_DATA_WIDTH-1:0] data,
  input  logic                        abtr_grant,
  output logic                        abtr_reqcyc,
  output logic                        bus_busy,
  output logic                        main_bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0]   main_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]    main_bus_reqtag,
  input  logic                        main_bus_reqack,
  output logic                        ready
);

  localparam int BEATS = 8;

  typedef enum logic [2:0] {IDLE, ARB, ADDR, DATA, RELEASE, READY} state_t;

  state_t                                 state, nxt;
  logic [2:0]                             cnt, cnt_nxt;
  logic [63:0]                            addr_buf;
  logic [BEATS-1:0][BUS_DATA_WIDTH-1:0]   data_buf;
  logic                                   start;

  assign start = (state == IDLE || state == READY) && enable;

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    case (state)
      IDLE, READY: if (enable) nxt = ARB;
      ARB:         if (abtr_grant) nxt = ADDR;
      ADDR: if (main_bus_reqack) begin
        nxt     = DATA;
        cnt_nxt = 3'd0;
      end
      DATA: begin
        if (cnt == 3'(BEATS - 1)) nxt = RELEASE;
        else cnt_nxt = cnt + 3'd1;
      end
      RELEASE:     nxt = READY;
      default:     nxt = IDLE;
    endcase
  end

  // Outputs are registered off the next state, so each one is a pure
  // function of the state/counter/buffers visible in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= 3'd0;
      abtr_reqcyc     <= 1'b0;
      bus_busy        <= 1'b0;
      main_bus_reqcyc <= 1'b0;
      main_bus_req    <= '0;
      main_bus_reqtag <= '0;
      ready           <= 1'b0;
    end else begin
      state           <= nxt;
      cnt             <= cnt_nxt;
      abtr_reqcyc     <= (nxt == ARB);
      bus_busy        <= (nxt == ADDR) || (nxt == DATA) || (nxt == RELEASE);
      main_bus_reqcyc <= (nxt == ADDR) || (nxt == DATA);
      main_bus_reqtag <= ((nxt == ADDR) || (nxt == DATA)) ? WRITE_TAG : '0;
      ready           <= (nxt == READY);
      if (nxt == ADDR)      main_bus_req <= BUS_DATA_WIDTH'(addr_buf);
      else if (nxt == DATA) main_bus_req <= data_buf[cnt_nxt];
      else                  main_bus_req <= '0;
    end
  end

  // Buffers only load when a write-back starts; their reset value is irrelevant.
  always_ff @(posedge clk) begin
    if (!reset && start) begin
      addr_buf <= {addr[63:6], 6'b0};
      data_buf <= data;
    end
  end

endmodule
